// File: rtl/taxi_eth_phy_10g_pkg.sv
// Shared 10GBASE-R PCS definitions: block geometry, sync header codes and
// the 66-bit block type used by the gearbox and frame-sync stages.
package taxi_eth_phy_10g_pkg;

  localparam int BLOCK_W = 66;
  localparam int DATA_W  = 64;
  localparam int HDR_W   = 2;

  localparam logic [HDR_W-1:0] SYNC_DATA = 2'b10;
  localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b01;

  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/taxi_eth_phy_10g_rx_gearbox.sv
// 10GBASE-R RX 64:66 gearbox. Accepts one 64-bit SERDES word per clock and
// repacks the bit stream into 66-bit blocks (header in bits [1:0]). Each
// cycle with serdes_rx_bitslip high discards the oldest unconsumed bit.
// Optional feature macro: TAXI_ETH_PHY_10G_RX_GEARBOX_POL_EN adds the
// cfg_rx_polarity input, which inverts the incoming SERDES bits.
module taxi_eth_phy_10g_rx_gearbox
  import taxi_eth_phy_10g_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TAXI_ETH_PHY_10G_RX_GEARBOX_POL_EN
  input  logic              cfg_rx_polarity,
`endif
  input  logic [DATA_W-1:0] serdes_rx_data,
  input  logic              serdes_rx_bitslip,
  output logic [DATA_W-1:0] rx_data,
  output logic [HDR_W-1:0]  rx_hdr,
  output logic              rx_hdr_valid
);

  if (DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "taxi_eth_phy_10g_rx_gearbox: DATA_W must be 64");
  end
  if (HDR_W != 2) begin : g_bad_hdr_w
    $fatal(1, "taxi_eth_phy_10g_rx_gearbox: HDR_W must be 2");
  end

  // Buffer holds up to 65 leftover bits; merged word is buffer plus one input word.
  localparam int BUF_W   = BLOCK_W - 1;
  localparam int WORK_W  = BUF_W + DATA_W;
  localparam int CNT_W   = 7;
  localparam int AVAIL_W = 8;

  logic [DATA_W-1:0]  din_p0;
  logic [WORK_W-1:0]  work_p0;
  logic [AVAIL_W-1:0] avail_p0;
  logic               emit_p0;
  block_t             blk_p0;
  logic [BUF_W-1:0]   buf_next;
  logic [CNT_W-1:0]   cnt_next;

  // Oldest unconsumed bits, LSB first; bits at and above cnt are always zero.
  logic [BUF_W-1:0]   bit_buf;
  logic [CNT_W-1:0]   cnt;

`ifdef TAXI_ETH_PHY_10G_RX_GEARBOX_POL_EN
  assign din_p0 = serdes_rx_data ^ {DATA_W{cfg_rx_polarity}};
`else
  assign din_p0 = serdes_rx_data;
`endif

  // Merge new word above the leftover bits, apply slip, and carve off a block.
  always_comb begin
    work_p0  = {{(WORK_W-BUF_W){1'b0}}, bit_buf}
             | ({{(WORK_W-DATA_W){1'b0}}, din_p0} << cnt);
    avail_p0 = {1'b0, cnt} + AVAIL_W'(DATA_W);
    blk_p0   = '0;
    buf_next = work_p0[BUF_W-1:0];
    cnt_next = avail_p0[CNT_W-1:0];

    if (serdes_rx_bitslip) begin
      work_p0  = work_p0 >> 1;
      avail_p0 = avail_p0 - AVAIL_W'(1);
    end

    emit_p0 = (avail_p0 >= AVAIL_W'(BLOCK_W));

    if (emit_p0) begin
      blk_p0   = work_p0[BLOCK_W-1:0];
      buf_next = BUF_W'(work_p0 >> BLOCK_W);
      cnt_next = CNT_W'(avail_p0 - AVAIL_W'(BLOCK_W));
    end else begin
      buf_next = work_p0[BUF_W-1:0];
      cnt_next = avail_p0[CNT_W-1:0];
    end
  end

  // ---- stage boundary: buffer state and registered block outputs ----
  // Outputs hold their last block on stall cycles; reset drops all buffered bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      bit_buf      <= '0;
      rx_data      <= '0;
      rx_hdr       <= '0;
      rx_hdr_valid <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      bit_buf      <= buf_next;
      rx_hdr_valid <= emit_p0;
      if (emit_p0) begin
        rx_hdr  <= blk_p0[HDR_W-1:0];
        rx_data <= blk_p0[BLOCK_W-1:HDR_W];
      end
    end
  end

endmodule
